// File: rtl/dmem_pkg.sv
// Shared types, constants and the request legality check for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 8;
  localparam int unsigned WORD_W         = 64;

  // Any true term rejects the access: exactly one of rd/wr, doubleword aligned, in range.
  function automatic logic access_error(input logic [WORD_W-1:0] addr,
                                        input logic              rd,
                                        input logic              wr,
                                        input int unsigned       depth);
    logic [WORD_W-1:0] limit;
    limit = 64'(depth) * 64'(BYTES_PER_WORD);
    return (rd && wr) || (!rd && !wr) || (addr[2:0] != 3'b000) || (addr >= limit);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU-side request/response bundle for the data-memory responder.
interface dmem_responder_if;

  logic                        REQ_VALID;
  logic                        REQ_READY;
  logic [dmem_pkg::WORD_W-1:0] ADDRESS;
  logic [dmem_pkg::WORD_W-1:0] WRITE_DATA;
  logic                        CONTROL_MEMREAD;
  logic                        CONTROL_MEMWRITE;
  logic                        RESP_VALID;
  logic                        RESP_READY;
  logic [dmem_pkg::WORD_W-1:0] READ_DATA;
  logic                        ERROR;

  modport master (
    output REQ_VALID, ADDRESS, WRITE_DATA, CONTROL_MEMREAD, CONTROL_MEMWRITE, RESP_READY,
    input  REQ_READY, RESP_VALID, READ_DATA, ERROR
  );

  modport slave (
    input  REQ_VALID, ADDRESS, WRITE_DATA, CONTROL_MEMREAD, CONTROL_MEMWRITE, RESP_READY,
    output REQ_READY, RESP_VALID, READ_DATA, ERROR
  );

endinterface

// File: rtl/dmem_array.sv
// Doubleword storage: one synchronous write port, one combinational read port. Not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128
) (
  input  logic                           CLOCK,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] windex,
  input  logic [WORD_W-1:0]              wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rindex,
  output logic [WORD_W-1:0]              rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Store commit.
  always_ff @(posedge CLOCK) begin
    if (we) begin
      mem[windex] <= wdata;
    end
  end

  assign rdata = mem[rindex];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits WAIT_STATES cycles,
// then holds a response (read data + error) until the CPU takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q, wdata_q;
  logic              rd_q, wr_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;

  logic              accept;
  logic              enter_resp;
  logic [WORD_W-1:0] cur_addr, cur_wdata;
  logic              cur_rd, cur_wr, cur_err;
  logic [IDX_W-1:0]  cur_idx;
  logic              arr_we;
  logic [WORD_W-1:0] arr_rdata;

  // Next-state logic for the IDLE/WAIT/RESP sequencer and its wait counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.REQ_VALID) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.RESP_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access completes on the accept edge, so the live request is used.
  always_comb begin
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_rd    = rd_q;
    cur_wr    = wr_q;
    if (state_q == IDLE) begin
      cur_addr  = bus.ADDRESS;
      cur_wdata = bus.WRITE_DATA;
      cur_rd    = bus.CONTROL_MEMREAD;
      cur_wr    = bus.CONTROL_MEMWRITE;
    end
    cur_err = access_error(cur_addr, cur_rd, cur_wr, DEPTH_WORDS);
    cur_idx = cur_addr[IDX_W+2:3];
    arr_we  = enter_resp && cur_wr && !cur_err;
  end

  // Sequencer state and wait counter.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch; inputs are ignored after acceptance.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.ADDRESS;
      wdata_q <= bus.WRITE_DATA;
      rd_q    <= bus.CONTROL_MEMREAD;
      wr_q    <= bus.CONTROL_MEMWRITE;
    end
  end

  // Response registers, loaded on the edge entering RESP and held until the next access.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= cur_err;
      rdata_q <= (cur_rd && !cur_err) ? arr_rdata : '0;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .CLOCK  (CLOCK),
    .we     (arr_we),
    .windex (cur_idx),
    .wdata  (cur_wdata),
    .rindex (cur_idx),
    .rdata  (arr_rdata)
  );

  assign bus.REQ_READY  = (state_q == IDLE);
  assign bus.RESP_VALID = (state_q == RESP);
  assign bus.READ_DATA  = rdata_q;
  assign bus.ERROR      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances (0 and 2 wait states), a vector table of
// accesses, and hand-written sequences for backpressure, back-to-back and reset corners.
module tb_dmem_responder;

  localparam int unsigned WS_A = 0;  // instance index 0
  localparam int unsigned WS_B = 2;  // instance index 1

  logic CLOCK;
  logic rst_n [2];

  logic        req_valid [2];
  logic        resp_ready [2];
  logic        mrd [2];
  logic        mwr [2];
  logic [63:0] addr [2];
  logic [63:0] wdata [2];

  logic        req_ready_s [2];
  logic        resp_valid_s [2];
  logic [63:0] read_data_s [2];
  logic        error_s [2];

  int total;
  int bad;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  assign bus0.REQ_VALID        = req_valid[0];
  assign bus0.RESP_READY       = resp_ready[0];
  assign bus0.CONTROL_MEMREAD  = mrd[0];
  assign bus0.CONTROL_MEMWRITE = mwr[0];
  assign bus0.ADDRESS          = addr[0];
  assign bus0.WRITE_DATA       = wdata[0];
  assign bus1.REQ_VALID        = req_valid[1];
  assign bus1.RESP_READY       = resp_ready[1];
  assign bus1.CONTROL_MEMREAD  = mrd[1];
  assign bus1.CONTROL_MEMWRITE = mwr[1];
  assign bus1.ADDRESS          = addr[1];
  assign bus1.WRITE_DATA       = wdata[1];

  assign req_ready_s[0]  = bus0.REQ_READY;
  assign resp_valid_s[0] = bus0.RESP_VALID;
  assign read_data_s[0]  = bus0.READ_DATA;
  assign error_s[0]      = bus0.ERROR;
  assign req_ready_s[1]  = bus1.REQ_READY;
  assign resp_valid_s[1] = bus1.RESP_VALID;
  assign read_data_s[1]  = bus1.READ_DATA;
  assign error_s[1]      = bus1.ERROR;

  dmem_responder #(
    .DEPTH_WORDS(128),
    .WAIT_STATES(WS_A)
  ) u_dut0 (
    .CLOCK   (CLOCK),
    .RESET_N (rst_n[0]),
    .bus     (bus0.slave)
  );

  dmem_responder #(
    .DEPTH_WORDS(128),
    .WAIT_STATES(WS_B)
  ) u_dut1 (
    .CLOCK   (CLOCK),
    .RESET_N (rst_n[1]),
    .bus     (bus1.slave)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int          d;
    logic        rd;
    logic        wr;
    logic [63:0] a;
    logic [63:0] wd;
    logic        early;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag, input int d);
    check({tag, " req_ready"}, 64'(req_ready_s[d]), 64'd1);
    check({tag, " resp_valid"}, 64'(resp_valid_s[d]), 64'd0);
    check({tag, " read_data"}, read_data_s[d], 64'd0);
    check({tag, " error"}, 64'(error_s[d]), 64'd0);
  endtask

  // lat counts clock edges from request presentation (accept edge included) to RESP_VALID.
  task automatic run_access(input int d, input logic rd, input logic wr, input logic [63:0] a,
                            input logic [63:0] wd, input logic early,
                            output logic [63:0] rdata, output logic err, output int lat);
    int n;
    @(negedge CLOCK);
    req_valid[d] = 1'b1;
    mrd[d]       = rd;
    mwr[d]       = wr;
    addr[d]      = a;
    wdata[d]     = wd;
    n = 0;
    while (!req_ready_s[d] && n < 50) begin
      @(negedge CLOCK);
      n++;
    end
    @(negedge CLOCK);
    req_valid[d] = 1'b0;
    addr[d]      = ~a;
    wdata[d]     = ~wd;
    if (early) resp_ready[d] = 1'b1;
    lat = 1;
    while (!resp_valid_s[d] && lat < 50) begin
      @(negedge CLOCK);
      lat++;
    end
    rdata = read_data_s[d];
    err   = error_s[d];
    resp_ready[d] = 1'b1;
    @(negedge CLOCK);
    resp_ready[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          n;

    total = 0;
    bad   = 0;
    for (int i = 0; i < 2; i++) begin
      rst_n[i]      = 1'b0;
      req_valid[i]  = 1'b0;
      resp_ready[i] = 1'b0;
      mrd[i]        = 1'b0;
      mwr[i]        = 1'b0;
      addr[i]       = '0;
      wdata[i]      = '0;
    end

    //        d  rd wr addr                    wdata                  early exp_rdata        err
    vecs[0]  = '{1, 0, 1, 64'h10,               64'hDEADBEEF_CAFEF00D, 0, 64'h0,                0};
    vecs[1]  = '{1, 1, 0, 64'h10,               64'h0,                 0, 64'hDEADBEEF_CAFEF00D, 0};
    vecs[2]  = '{1, 0, 1, 64'h0,                64'h11112222_33334444, 0, 64'h0,                0};
    vecs[3]  = '{1, 0, 1, 64'h8,                64'h0,                 1, 64'h0,                0};
    vecs[4]  = '{1, 0, 1, 64'h400,              64'hFFFFFFFF_FFFFFFFF, 0, 64'h0,                1};
    vecs[5]  = '{1, 1, 0, 64'h0,                64'h0,                 0, 64'h11112222_33334444, 0};
    vecs[6]  = '{1, 1, 0, 64'h13,               64'h0,                 0, 64'h0,                1};
    vecs[7]  = '{1, 1, 1, 64'h10,               64'hBAD,               0, 64'h0,                1};
    vecs[8]  = '{1, 0, 0, 64'h10,               64'hBAD,               0, 64'h0,                1};
    vecs[9]  = '{1, 0, 1, 64'h3F8,              64'hA5A5A5A5_5A5A5A5A, 1, 64'h0,                0};
    vecs[10] = '{1, 1, 0, 64'h3F8,              64'h0,                 0, 64'hA5A5A5A5_5A5A5A5A, 0};
    vecs[11] = '{1, 1, 0, 64'h80000000_00000010, 64'h0,                0, 64'h0,                1};
    vecs[12] = '{1, 1, 0, 64'h10,               64'h0,                 1, 64'hDEADBEEF_CAFEF00D, 0};
    vecs[13] = '{0, 0, 1, 64'h20,               64'h01234567_89ABCDEF, 0, 64'h0,                0};
    vecs[14] = '{0, 1, 0, 64'h20,               64'h0,                 0, 64'h01234567_89ABCDEF, 0};
    vecs[15] = '{0, 0, 1, 64'h21,               64'h5555,              0, 64'h0,                1};
    vecs[16] = '{0, 1, 0, 64'h20,               64'h0,                 1, 64'h01234567_89ABCDEF, 0};

    repeat (2) @(negedge CLOCK);
    check_reset("rst0", 0);
    check_reset("rst1", 1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge CLOCK);

    for (int i = 0; i < 17; i++) begin
      run_access(vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].early,
                 rdata, err, lat);
      check($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d error", i), 64'(err), 64'(vecs[i].exp_err));
      check($sformatf("v%0d latency", i), 64'(lat),
            64'((vecs[i].d == 0) ? WS_A + 1 : WS_B + 1));
    end

    // Back-to-back loads with zero wait states and RESP_READY tied high: one per 2 cycles.
    @(negedge CLOCK);
    req_valid[0]  = 1'b1;
    mrd[0]        = 1'b1;
    mwr[0]        = 1'b0;
    addr[0]       = 64'h20;
    resp_ready[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("b2b%0d req_ready", k), 64'(req_ready_s[0]), 64'((k % 2) == 0));
      check($sformatf("b2b%0d resp_valid", k), 64'(resp_valid_s[0]), 64'((k % 2) == 1));
      if ((k % 2) == 1) check($sformatf("b2b%0d rdata", k), read_data_s[0],
                              64'h01234567_89ABCDEF);
      @(negedge CLOCK);
    end
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b0;

    // Backpressure: response held for 5 stalled cycles; a request overlapping the handshake
    // must not be taken.
    @(negedge CLOCK);
    check("bp idle", 64'(req_ready_s[1]), 64'd1);
    req_valid[1] = 1'b1;
    mrd[1]       = 1'b1;
    mwr[1]       = 1'b0;
    addr[1]      = 64'h10;
    @(negedge CLOCK);
    req_valid[1] = 1'b0;
    addr[1]      = 64'h18;
    n = 0;
    while (!resp_valid_s[1] && n < 50) begin
      @(negedge CLOCK);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLOCK);
      check($sformatf("bp%0d resp_valid", k), 64'(resp_valid_s[1]), 64'd1);
      check($sformatf("bp%0d rdata", k), read_data_s[1], 64'hDEADBEEF_CAFEF00D);
      check($sformatf("bp%0d error", k), 64'(error_s[1]), 64'd0);
      check($sformatf("bp%0d req_ready", k), 64'(req_ready_s[1]), 64'd0);
    end
    req_valid[1]  = 1'b1;
    mrd[1]        = 1'b0;
    mwr[1]        = 1'b1;
    addr[1]       = 64'h30;
    wdata[1]      = 64'h1234;
    resp_ready[1] = 1'b1;
    @(negedge CLOCK);
    req_valid[1]  = 1'b0;
    resp_ready[1] = 1'b0;
    check("bp release req_ready", 64'(req_ready_s[1]), 64'd1);
    check("bp release resp_valid", 64'(resp_valid_s[1]), 64'd0);

    // Reset in WAIT during a store of 0x55 to 0x8: aborted, no commit.
    @(negedge CLOCK);
    req_valid[1] = 1'b1;
    mrd[1]       = 1'b0;
    mwr[1]       = 1'b1;
    addr[1]      = 64'h8;
    wdata[1]     = 64'h55;
    @(negedge CLOCK);
    req_valid[1] = 1'b0;
    check("wait state busy", 64'(req_ready_s[1]), 64'd0);
    rst_n[1] = 1'b0;
    #1;
    check_reset("rst wait", 1);
    @(negedge CLOCK);
    rst_n[1] = 1'b1;
    repeat (4) @(negedge CLOCK);
    check("post rst resp_valid", 64'(resp_valid_s[1]), 64'd0);
    run_access(1, 1'b1, 1'b0, 64'h8, 64'h0, 1'b0, rdata, err, lat);
    check("after abort rdata", rdata, 64'h0);
    check("after abort error", 64'(err), 64'd0);

    // Reset in RESP: response dropped, committed store kept.
    @(negedge CLOCK);
    req_valid[1] = 1'b1;
    mrd[1]       = 1'b0;
    mwr[1]       = 1'b1;
    addr[1]      = 64'h18;
    wdata[1]     = 64'h77;
    @(negedge CLOCK);
    req_valid[1] = 1'b0;
    n = 0;
    while (!resp_valid_s[1] && n < 50) begin
      @(negedge CLOCK);
      n++;
    end
    check("resp reached", 64'(resp_valid_s[1]), 64'd1);
    rst_n[1] = 1'b0;
    #1;
    check("rst resp resp_valid", 64'(resp_valid_s[1]), 64'd0);
    @(negedge CLOCK);
    rst_n[1] = 1'b1;
    run_access(1, 1'b1, 1'b0, 64'h18, 64'h0, 1'b0, rdata, err, lat);
    check("kept store rdata", rdata, 64'h77);
    check("kept store error", 64'(err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
